// File: rtl/card_match_engine.sv
// Memory-card game engine: flips, pair checks, mismatch hold, move/pair counts.
// Define CARD_MATCH_MOVES_EN to build the saturating moves counter.
module card_match_engine #(
  parameter int NUM_PAIRS   = 8,
  parameter int HIDE_CYCLES = 50_000_000,
  parameter int POS_W       = $clog2(2*NUM_PAIRS),
  parameter int ID_W        = ($clog2(NUM_PAIRS) < 1) ? 1 : $clog2(NUM_PAIRS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             new_game,
  input  logic [2*NUM_PAIRS*ID_W-1:0]      card_ids,
  input  logic                             sel_valid,
  input  logic [POS_W-1:0]                 sel_pos,
  input  logic                             unselect_all,
  output logic                             sel_ack,
  output logic [2*NUM_PAIRS-1:0]           face_up,
  output logic [2*NUM_PAIRS-1:0]           matched,
  output logic                             match_pulse,
  output logic                             mismatch,
  output logic [$clog2(NUM_PAIRS+1)-1:0]   pairs_left,
  output logic [15:0]                      moves,
  output logic                             game_over,
  output logic                             busy
);

  localparam int NUM_CARDS = 2*NUM_PAIRS;
  localparam int PL_W      = $clog2(NUM_PAIRS+1);
  localparam int CNT_W     = $clog2(HIDE_CYCLES+1);

  typedef enum logic [2:0] {
    IDLE, ONE_UP, CHECK, SHOW, DONE
  } state_t;

  state_t           state;
  logic [POS_W-1:0] pos_a;
  logic [POS_W-1:0] pos_b;
  logic [CNT_W-1:0] hide_cnt;

  logic                 clr;
  logic                 in_range;
  logic                 accept;
  logic                 same_id;
  logic [NUM_CARDS-1:0] sel_mask;
  logic [NUM_CARDS-1:0] a_mask;
  logic [NUM_CARDS-1:0] b_mask;
  logic [ID_W-1:0]      id_a;
  logic [ID_W-1:0]      id_b;

  assign clr      = reset | new_game;
  assign in_range = int'(sel_pos) < NUM_CARDS;
  // Out-of-range shifts yield an all-zero mask, so no bounds hazard.
  assign sel_mask = NUM_CARDS'(1) << sel_pos;
  assign a_mask   = NUM_CARDS'(1) << pos_a;
  assign b_mask   = NUM_CARDS'(1) << pos_b;
  assign id_a     = card_ids[int'(pos_a)*ID_W +: ID_W];
  assign id_b     = card_ids[int'(pos_b)*ID_W +: ID_W];
  assign same_id  = id_a == id_b;
  assign accept   = sel_valid && !unselect_all && in_range &&
                    ((face_up & sel_mask) == '0);
  assign busy     = (state == CHECK) || (state == SHOW);

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      pos_a       <= '0;
      pos_b       <= '0;
      hide_cnt    <= '0;
      sel_ack     <= 1'b0;
      face_up     <= '0;
      matched     <= '0;
      match_pulse <= 1'b0;
      mismatch    <= 1'b0;
      pairs_left  <= PL_W'(NUM_PAIRS);
      game_over   <= 1'b0;
    end else begin
      sel_ack     <= 1'b0;
      match_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            face_up <= face_up | sel_mask;
            pos_a   <= sel_pos;
            sel_ack <= 1'b1;
            state   <= ONE_UP;
          end
        end
        ONE_UP: begin
          if (unselect_all) begin
            face_up <= matched;
            state   <= IDLE;
          end else if (accept) begin
            face_up <= face_up | sel_mask;
            pos_b   <= sel_pos;
            sel_ack <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (same_id) begin
            matched     <= matched | a_mask | b_mask;
            match_pulse <= 1'b1;
            pairs_left  <= pairs_left - 1'b1;
            if (pairs_left == PL_W'(1)) begin
              game_over <= 1'b1;
              state     <= DONE;
            end else begin
              state <= IDLE;
            end
          end else begin
            mismatch <= 1'b1;
            hide_cnt <= CNT_W'(HIDE_CYCLES-1);
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (unselect_all) begin
            face_up  <= matched;
            mismatch <= 1'b0;
            state    <= IDLE;
          end else if (hide_cnt == '0) begin
            face_up  <= face_up & ~(a_mask | b_mask);
            mismatch <= 1'b0;
            state    <= IDLE;
          end else begin
            hide_cnt <= hide_cnt - 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CARD_MATCH_MOVES_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      moves <= '0;
    end else if (state == CHECK && moves != 16'hFFFF) begin
      moves <= moves + 16'd1;
    end
  end
`else
  assign moves = '0;
`endif

endmodule

// File: tb/tb_card_match_engine.sv
// Self-checking bench for card_match_engine (2 pairs, 4-cycle hide).
module tb_card_match_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic [3:0] card_ids = 4'b1010;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_pos = '0;
  logic       unselect_all = 1'b0;
  logic       sel_ack;
  logic [3:0] face_up;
  logic [3:0] matched;
  logic       match_pulse;
  logic       mismatch;
  logic [1:0] pairs_left;
  logic [15:0] moves;
  logic       game_over;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int exp_moves = 0;
  bit ack_q[$];
  logic pend = 1'b0;

  card_match_engine #(
    .NUM_PAIRS(2), .HIDE_CYCLES(4), .POS_W(3)
  ) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .card_ids(card_ids), .sel_valid(sel_valid),
    .sel_pos(sel_pos), .unselect_all(unselect_all),
    .sel_ack(sel_ack), .face_up(face_up), .matched(matched),
    .match_pulse(match_pulse), .mismatch(mismatch),
    .pairs_left(pairs_left), .moves(moves),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) pend <= sel_valid;

  always @(negedge clk) begin
    if (pend) begin
      if (ack_q.size() == 0) chk("ack_q_underflow", 1, 0);
      else chk("sel_ack", sel_ack, ack_q.pop_front());
    end else if (sel_ack) begin
      chk("spurious_ack", sel_ack, 0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic sel(input logic [2:0] p, input bit exp);
    sel_pos = p;
    sel_valid = 1'b1;
    ack_q.push_back(exp);
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic bump_moves();
`ifdef CARD_MATCH_MOVES_EN
    exp_moves++;
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_face"}, face_up, 0);
    chk({tag, "_matched"}, matched, 0);
    chk({tag, "_pairs"}, pairs_left, 2);
    chk({tag, "_moves"}, moves, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_mism"}, mismatch, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk_reset_state("rst");

    // mismatch with a rejected select during SHOW
    sel(0, 1);
    chk("flip0_face", face_up, 4'b0001);
    sel(1, 1);
    chk("check_busy", busy, 1);
    cyc();
    bump_moves();
    chk("mism_rise", mismatch, 1);
    chk("mism_moves", moves, exp_moves);
    n = 0;
    if (mismatch) begin
      n = 1;
      sel(2, 0);
    end
    while (mismatch && n < 20) begin
      n++;
      cyc();
    end
    chk("mism_len", n, 4);
    chk("mism_face", face_up, 0);
    chk("mism_busy", busy, 0);

    // rejected selections
    sel(0, 1);
    sel(0, 0);
    sel(4, 0);
    chk("rej_face", face_up, 4'b0001);

    // unselect_all in ONE_UP
    unselect_all = 1'b1;
    cyc();
    unselect_all = 1'b0;
    chk("unsel_face", face_up, 0);
    chk("unsel_moves", moves, exp_moves);
    sel(0, 1);
    unselect_all = 1'b1;
    sel(1, 0);
    unselect_all = 1'b0;
    chk("unsel_sel_face", face_up, 0);

    // first match
    sel(0, 1);
    sel(2, 1);
    chk("m1_nopulse", match_pulse, 0);
    cyc();
    bump_moves();
    chk("m1_pulse", match_pulse, 1);
    chk("m1_matched", matched, 4'b0101);
    chk("m1_pairs", pairs_left, 1);
    chk("m1_moves", moves, exp_moves);
    chk("m1_over", game_over, 0);
    cyc();
    chk("m1_pulse_end", match_pulse, 0);

    // second match ends the game
    sel(1, 1);
    sel(3, 1);
    cyc();
    bump_moves();
    chk("m2_pulse", match_pulse, 1);
    chk("m2_over", game_over, 1);
    chk("m2_pairs", pairs_left, 0);
    chk("m2_matched", matched, 4'b1111);
    chk("m2_moves", moves, exp_moves);
    sel(0, 0);
    unselect_all = 1'b1;
    cyc();
    unselect_all = 1'b0;
    chk("done_face", face_up, 4'b1111);
    chk("done_over", game_over, 1);

    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    exp_moves = 0;
    chk_reset_state("newgame");

    // reset during SHOW
    sel(0, 1);
    sel(3, 1);
    cyc();
    chk("show_mism", mismatch, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_show_mism", mismatch, 0);
    chk("rst_show_face", face_up, 0);
    chk("rst_show_moves", moves, 0);
    cyc();
    chk("ack_q_empty", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
